multicycle_sequencer: RTL and testbench
=======================================

Name: multicycle_sequencer

Overview:
- Parametrised successor to the fixed 4-bit multicycle control FSM and its decoder. It merges both into one registered sequencer.
- Adds features the old controller lacks: a variable-latency memory handshake with wait states, HALT, synchronous reset, and retired-instruction and cycle counters.
- Sits between the instruction register opcode field and the datapath muxes, register file, ALU and PC of the multicycle core.

Parameters:
- OP_SIZE, 6, opcode width.
- ALU_OP_SIZE, 4, alu_op width.
- COUNT_WIDTH, 32, width of cycle_count and retired_count.
- OPC_LOAD, 6'h01, load opcode.
- OPC_STORE, 6'h02, store opcode.
- OPC_BRANCH, 6'h03, conditional branch opcode.
- OPC_JUMP, 6'h04, jump opcode.
- OPC_LOADI, 6'h05, load-immediate opcode.
- OPC_HALT, 6'h3F, halt opcode.
- ALU_ADD, 4'h0, alu_op code for add.
- ALU_CMP, 4'h1, alu_op code for compare (result LSB = taken).
- MEM_TIMEOUT, 16, maximum wait cycles. Used only when the optional feature is enabled.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  OP_SIZE  IR opcode field; sampled in DECODE.
- mem_ready  in  1  memory completes the current request this cycle.
- branch_taken  in  1  ALU result LSB; valid in BRANCH.
- state  out  4  current FSM state (encoding below).
- mem_req  out  1  memory access request.
- mem_write  out  1  qualifies mem_req as a store.
- mem_addr_sel  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load the IR.
- pc_write  out  1  load the PC (already combined with branch_taken).
- pc_src  out  2  PC source: 0 = ALUOut, 1 = jump address, 2 = ALU direct.
- reg_write  out  1  register file write enable.
- reg_write_sel  out  2  write data: 0 = MDR, 1 = ALUOut, 2 = sign-extended big immediate.
- alu_src_a  out  1  ALU A: 0 = PC, 1 = register bus A.
- alu_src_b  out  2  ALU B: 0 = 4, 1 = register bus B, 2 = shifted offset, 3 = offset.
- alu_op  out  ALU_OP_SIZE  ALU operation.
- retire  out  1  one-cycle pulse in the last cycle of each instruction.
- halted  out  1  high while in HALT.
- fault  out  1  memory timeout flag; tied 0 without the optional feature.
- cycle_count  out  COUNT_WIDTH  cycles since reset.
- retired_count  out  COUNT_WIDTH  instructions retired.

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEMADDR=3, MEMRD=4, MEMWR=5, WB_ALU=6, WB_MEM=7, WB_IMM=8, BRANCH=9, JUMP=10, HALT=11, FAULT=12.
- Reset (any cycle, mid-instruction included): next state FETCH, both counters 0. All control outputs are combinational from state, opcode and inputs. Every output not listed for a state is 0; alu_op defaults to ALU_ADD.
- FETCH:
  - Drives mem_req=1, mem_addr_sel=0, alu_src_a=0, alu_src_b=0.
  - If mem_ready=0: stay in FETCH, no other strobes.
  - If mem_ready=1: ir_write=1, pc_write=1, pc_src=2, next DECODE.
- DECODE: alu_src_a=0, alu_src_b=2 (precomputes the branch target into ALUOut). Next state by opcode:
  - LOAD or STORE -> MEMADDR.
  - BRANCH -> BRANCH.
  - JUMP -> JUMP.
  - LOADI -> WB_IMM.
  - HALT -> HALT.
  - any other opcode -> EXEC.
- EXEC: alu_src_a=1, alu_src_b=1, alu_op=opcode[ALU_OP_SIZE-1:0]; next WB_ALU.
- WB_ALU: reg_write=1, reg_write_sel=1, retire=1; next FETCH.
- MEMADDR: alu_src_a=1, alu_src_b=3; next MEMRD for a load, MEMWR for a store.
- MEMRD: mem_req=1, mem_addr_sel=1; stays until mem_ready=1, then WB_MEM.
- WB_MEM: reg_write=1, reg_write_sel=0, retire=1; next FETCH.
- MEMWR: mem_req=1, mem_write=1, mem_addr_sel=1; stays until mem_ready=1. In the completing cycle it asserts retire=1, then goes to FETCH.
- WB_IMM: reg_write=1, reg_write_sel=2, retire=1; next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=1, alu_op=ALU_CMP, pc_src=0, pc_write=branch_taken, retire=1; next FETCH.
- JUMP: pc_write=1, pc_src=1, retire=1; next FETCH.
- HALT: halted=1; sticky until reset. retire=1 in the first HALT cycle only.
- Instruction latencies with zero-wait memory:
  - ALU op: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - LOADI, BRANCH and JUMP: 3 cycles.
  - Each memory wait cycle adds 1.
- cycle_count: increments every non-reset cycle, including HALT. Wraps modulo 2^COUNT_WIDTH.
- retired_count: increments on retire. Wraps the same way.
- mem_ready outside FETCH, MEMRD and MEMWR is ignored.

Optional Feature:
- Macro: MCSEQ_MEM_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to FETCH, MEMRD or MEMWR and increments each cycle that mem_ready=0.
  - When the counter reaches MEM_TIMEOUT with mem_ready still 0, the next state is FAULT.
  - FAULT: fault=1, all strobes 0, sticky until reset. No retire.
  - mem_ready=1 in the same cycle the limit is reached wins: the access completes normally.
- Undefined: no counter, fault tied 0, FAULT is unreachable, and wait states are unbounded.

Test Plan:
- Reset, then ALU opcode 6'h10 with mem_ready=1 constantly:
  - States go 0,1,2,6,0.
  - retire pulses in cycle 4, retired_count=1, alu_op=4'h0 in EXEC.
- LOAD with mem_ready low 3 cycles in FETCH and 2 cycles in MEMRD:
  - Instruction takes 10 cycles.
  - ir_write is asserted exactly once.
  - reg_write_sel=0 in WB_MEM.
- BRANCH twice:
  - branch_taken=1: pc_write=1 with pc_src=0.
  - branch_taken=0: pc_write=0.
  - retired_count goes 1, then 2.
- HALT opcode:
  - halted=1 from cycle 3 on, retire pulses once.
  - cycle_count keeps counting for 20 cycles; state stays 11.
- Reset asserted in MEMRD: next state 0, counters 0, mem_req=1 from FETCH.
- With MCSEQ_MEM_TIMEOUT_EN and MEM_TIMEOUT=16:
  - mem_ready held 0 in FETCH gives fault=1 and state=12 after 17 cycles.
  - mem_ready=1 on the 16th wait cycle completes the fetch normally.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// Registered multicycle control sequencer: state, decode, memory handshake, HALT and counters.
// Define MCSEQ_MEM_TIMEOUT_EN to bound memory wait states and trap to FAULT on expiry.
module multicycle_sequencer #(
  parameter int unsigned OP_SIZE     = 6,
  parameter int unsigned ALU_OP_SIZE = 4,
  parameter int unsigned COUNT_WIDTH = 32,
  parameter logic [OP_SIZE-1:0] OPC_LOAD   = 6'h01,
  parameter logic [OP_SIZE-1:0] OPC_STORE  = 6'h02,
  parameter logic [OP_SIZE-1:0] OPC_BRANCH = 6'h03,
  parameter logic [OP_SIZE-1:0] OPC_JUMP   = 6'h04,
  parameter logic [OP_SIZE-1:0] OPC_LOADI  = 6'h05,
  parameter logic [OP_SIZE-1:0] OPC_HALT   = 6'h3F,
  parameter logic [ALU_OP_SIZE-1:0] ALU_ADD = 4'h0,
  parameter logic [ALU_OP_SIZE-1:0] ALU_CMP = 4'h1,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [OP_SIZE-1:0]     opcode,
  input  logic                   mem_ready,
  input  logic                   branch_taken,
  output logic [3:0]             state,
  output logic                   mem_req,
  output logic                   mem_write,
  output logic                   mem_addr_sel,
  output logic                   ir_write,
  output logic                   pc_write,
  output logic [1:0]             pc_src,
  output logic                   reg_write,
  output logic [1:0]             reg_write_sel,
  output logic                   alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [ALU_OP_SIZE-1:0] alu_op,
  output logic                   retire,
  output logic                   halted,
  output logic                   fault,
  output logic [COUNT_WIDTH-1:0] cycle_count,
  output logic [COUNT_WIDTH-1:0] retired_count
);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StExec    = 4'd2,
    StMemAddr = 4'd3,
    StMemRd   = 4'd4,
    StMemWr   = 4'd5,
    StWbAlu   = 4'd6,
    StWbMem   = 4'd7,
    StWbImm   = 4'd8,
    StBranch  = 4'd9,
    StJump    = 4'd10,
    StHalt    = 4'd11,
    StFault   = 4'd12
  } state_e;

  if (MEM_TIMEOUT == 0) begin : g_bad_timeout
    $error("MEM_TIMEOUT must be at least 1");
  end

  state_e                 state_q, state_d;
  logic                   halt_seen_q;
  logic [COUNT_WIDTH-1:0] cycle_q, retired_q;
  logic                   timeout;

  assign state         = state_q;
  assign cycle_count   = cycle_q;
  assign retired_count = retired_q;

`ifdef MCSEQ_MEM_TIMEOUT_EN
  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

  logic [WaitW-1:0] wait_q, wait_d;
  logic             mem_state;

  assign mem_state = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
  // Last permitted wait cycle; a ready in this same cycle still completes the access.
  assign timeout   = mem_state && !mem_ready && (wait_q == WaitLast);
  assign fault     = (state_q == StFault);

  // Every entry into a memory state comes from a different state, so a change clears it.
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (mem_state && !mem_ready) begin
      wait_d = wait_q + WaitW'(1);
    end
  end
`else
  assign timeout = 1'b0;
  assign fault   = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    mem_addr_sel  = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src        = 2'd0;
    reg_write     = 1'b0;
    reg_write_sel = 2'd0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    alu_op        = ALU_ADD;
    retire        = 1'b0;
    halted        = 1'b0;
    case (state_q)
      StFetch: begin
        mem_req = 1'b1;
        if (timeout) begin
          state_d = StFault;
        end else if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          pc_src   = 2'd2;
          state_d  = StDecode;
        end
      end
      StDecode: begin
        // ALUOut gets PC + shifted offset, ready for a branch.
        alu_src_b = 2'd2;
        if (opcode == OPC_LOAD || opcode == OPC_STORE) state_d = StMemAddr;
        else if (opcode == OPC_BRANCH)                 state_d = StBranch;
        else if (opcode == OPC_JUMP)                   state_d = StJump;
        else if (opcode == OPC_LOADI)                  state_d = StWbImm;
        else if (opcode == OPC_HALT)                   state_d = StHalt;
        else                                           state_d = StExec;
      end
      StExec: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd1;
        alu_op    = opcode[ALU_OP_SIZE-1:0];
        state_d   = StWbAlu;
      end
      StMemAddr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd3;
        state_d   = (opcode == OPC_STORE) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        if (timeout)        state_d = StFault;
        else if (mem_ready) state_d = StWbMem;
      end
      StMemWr: begin
        mem_req      = 1'b1;
        mem_write    = 1'b1;
        mem_addr_sel = 1'b1;
        if (timeout) begin
          state_d = StFault;
        end else if (mem_ready) begin
          retire  = 1'b1;
          state_d = StFetch;
        end
      end
      StWbAlu: begin
        reg_write     = 1'b1;
        reg_write_sel = 2'd1;
        retire        = 1'b1;
        state_d       = StFetch;
      end
      StWbMem: begin
        reg_write     = 1'b1;
        reg_write_sel = 2'd0;
        retire        = 1'b1;
        state_d       = StFetch;
      end
      StWbImm: begin
        reg_write     = 1'b1;
        reg_write_sel = 2'd2;
        retire        = 1'b1;
        state_d       = StFetch;
      end
      StBranch: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd1;
        alu_op    = ALU_CMP;
        pc_src    = 2'd0;
        pc_write  = branch_taken;
        retire    = 1'b1;
        state_d   = StFetch;
      end
      StJump: begin
        pc_write = 1'b1;
        pc_src   = 2'd1;
        retire   = 1'b1;
        state_d  = StFetch;
      end
      StHalt: begin
        halted = 1'b1;
        retire = !halt_seen_q;
      end
      StFault: begin
        state_d = StFault;
      end
      default: begin
        state_d = StFetch;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StFetch;
      halt_seen_q <= 1'b0;
      cycle_q     <= '0;
      retired_q   <= '0;
`ifdef MCSEQ_MEM_TIMEOUT_EN
      wait_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      halt_seen_q <= (state_q == StHalt);
      cycle_q     <= cycle_q + COUNT_WIDTH'(1);
      if (retire) retired_q <= retired_q + COUNT_WIDTH'(1);
`ifdef MCSEQ_MEM_TIMEOUT_EN
      wait_q      <= wait_d;
`endif
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench: each step pushes the expected state, control word and counters to a
// scoreboard, then pops and compares against the DUT mid-cycle.
module tb_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  opcode = 6'h00;
  logic        mem_ready = 1'b0;
  logic        branch_taken = 1'b0;
  logic [3:0]  state;
  logic        mem_req, mem_write, mem_addr_sel, ir_write, pc_write;
  logic [1:0]  pc_src;
  logic        reg_write;
  logic [1:0]  reg_write_sel;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [3:0]  alu_op;
  logic        retire, halted, fault;
  logic [31:0] cycle_count, retired_count;

  multicycle_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .mem_ready    (mem_ready),
    .branch_taken (branch_taken),
    .state        (state),
    .mem_req      (mem_req),
    .mem_write    (mem_write),
    .mem_addr_sel (mem_addr_sel),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .reg_write    (reg_write),
    .reg_write_sel(reg_write_sel),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .retire       (retire),
    .halted       (halted),
    .fault        (fault),
    .cycle_count  (cycle_count),
    .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [3:0]  st;
    logic [19:0] ctrl;
    logic [31:0] cyc;
    logic [31:0] ret;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cyc_m = 0;
  logic [31:0] ret_m = 0;
  logic [3:0]  prev_st = 4'd0;
  int          ir_seen = 0;

  // Control word {mem_req,mem_write,mem_addr_sel,ir_write,pc_write,pc_src,reg_write,
  // reg_write_sel,alu_src_a,alu_src_b,alu_op,retire,halted,fault}; retire is bit 2.
  function automatic logic [19:0] ctrl_of(input logic [3:0] st, input logic [5:0] op,
                                          input logic rdy, input logic bt, input logic first);
    logic mrq, mw, mas, irw, pcw, rw, sa, rt, hl, fl;
    logic [1:0] pcs, rws, sbv;
    logic [3:0] aop;
    {mrq, mw, mas, irw, pcw, rw, sa, rt, hl, fl} = '0;
    pcs = 2'd0; rws = 2'd0; sbv = 2'd0; aop = 4'h0;
    case (st)
      4'd0:  begin mrq = 1; if (rdy) begin irw = 1; pcw = 1; pcs = 2'd2; end end
      4'd1:  sbv = 2'd2;
      4'd2:  begin sa = 1; sbv = 2'd1; aop = op[3:0]; end
      4'd3:  begin sa = 1; sbv = 2'd3; end
      4'd4:  begin mrq = 1; mas = 1; end
      4'd5:  begin mrq = 1; mw = 1; mas = 1; rt = rdy; end
      4'd6:  begin rw = 1; rws = 2'd1; rt = 1; end
      4'd7:  begin rw = 1; rws = 2'd0; rt = 1; end
      4'd8:  begin rw = 1; rws = 2'd2; rt = 1; end
      4'd9:  begin sa = 1; sbv = 2'd1; aop = 4'h1; pcw = bt; rt = 1; end
      4'd10: begin pcw = 1; pcs = 2'd1; rt = 1; end
      4'd11: begin hl = 1; rt = first; end
      4'd12: fl = 1;
      default: ;
    endcase
    return {mrq, mw, mas, irw, pcw, pcs, rw, rws, sa, sbv, aop, rt, hl, fl};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [3:0] st, input logic rdy, input logic bt);
    exp_t        e;
    exp_t        g;
    logic [19:0] obs;
    mem_ready    = rdy;
    branch_taken = bt;
    e.tag  = tag;
    e.st   = st;
    e.ctrl = ctrl_of(st, opcode, rdy, bt, prev_st != 4'd11);
    e.cyc  = cyc_m;
    e.ret  = ret_m;
    sb.push_back(e);
    @(negedge clk);
    g   = sb.pop_front();
    obs = {mem_req, mem_write, mem_addr_sel, ir_write, pc_write, pc_src, reg_write,
           reg_write_sel, alu_src_a, alu_src_b, alu_op, retire, halted, fault};
    if (ir_write) ir_seen++;
    check({g.tag, "_state"}, 32'(state), 32'(g.st));
    check({g.tag, "_ctrl"}, 32'(obs), 32'(g.ctrl));
    check({g.tag, "_cycles"}, cycle_count, g.cyc);
    check({g.tag, "_retired"}, retired_count, g.ret);
    @(posedge clk);
    #1;
    cyc_m   = cyc_m + 1;
    ret_m   = ret_m + 32'(g.ctrl[2]);
    prev_st = st;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    cyc_m   = 0;
    ret_m   = 0;
    prev_st = 4'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    do_reset();

    // ALU op, zero-wait memory.
    opcode = 6'h10;
    step("alu_fetch", 4'd0, 1, 0);
    step("alu_decode", 4'd1, 1, 0);
    step("alu_exec", 4'd2, 1, 0);
    step("alu_wb", 4'd6, 1, 0);
    check("alu_retired_one", retired_count, 32'd1);

    // LOAD with 3 fetch waits and 2 read waits: 10 cycles.
    opcode  = 6'h01;
    ir_seen = 0;
    for (int i = 0; i < 3; i++) step("ld_fetch_wait", 4'd0, 0, 0);
    step("ld_fetch", 4'd0, 1, 0);
    step("ld_decode", 4'd1, 1, 0);
    step("ld_memaddr", 4'd3, 1, 0);
    for (int i = 0; i < 2; i++) step("ld_memrd_wait", 4'd4, 0, 0);
    step("ld_memrd", 4'd4, 1, 0);
    step("ld_wbmem", 4'd7, 0, 0);
    check("ld_ir_write_once", 32'(ir_seen), 32'd1);

    // STORE with one write wait.
    opcode = 6'h02;
    step("st_fetch", 4'd0, 1, 0);
    step("st_decode", 4'd1, 0, 0);
    step("st_memaddr", 4'd3, 0, 0);
    step("st_memwr_wait", 4'd5, 0, 0);
    step("st_memwr", 4'd5, 1, 0);

    // BRANCH taken, then not taken.
    opcode = 6'h03;
    step("br1_fetch", 4'd0, 1, 0);
    step("br1_decode", 4'd1, 1, 0);
    step("br1_taken", 4'd9, 1, 1);
    step("br2_fetch", 4'd0, 1, 0);
    step("br2_decode", 4'd1, 1, 0);
    step("br2_not_taken", 4'd9, 1, 0);
    check("br_retired_total", retired_count, 32'd5);

    opcode = 6'h05;
    step("li_fetch", 4'd0, 1, 0);
    step("li_decode", 4'd1, 1, 0);
    step("li_wbimm", 4'd8, 1, 0);

    opcode = 6'h04;
    step("jmp_fetch", 4'd0, 1, 0);
    step("jmp_decode", 4'd1, 1, 0);
    step("jmp_exec", 4'd10, 1, 1);

    // HALT is sticky; retire only in its first cycle, cycle_count keeps going.
    opcode = 6'h3F;
    step("halt_fetch", 4'd0, 1, 0);
    step("halt_decode", 4'd1, 1, 0);
    for (int i = 0; i < 21; i++) step("halt_hold", 4'd11, 1, 0);
    check("halt_retired_total", retired_count, 32'd8);

    // Reset in the middle of a load's MEMRD wait.
    do_reset();
    opcode = 6'h01;
    step("rst_fetch0", 4'd0, 1, 0);
    step("rst_decode", 4'd1, 1, 0);
    step("rst_memaddr", 4'd3, 1, 0);
    step("rst_memrd", 4'd4, 0, 0);
    do_reset();
    step("rst_after", 4'd0, 0, 0);
    step("rst_fetch1", 4'd0, 1, 0);
    step("rst_decode1", 4'd1, 1, 0);

`ifdef MCSEQ_MEM_TIMEOUT_EN
    // 16 waits in FETCH trap to FAULT; ready on the 16th cycle completes instead.
    do_reset();
    opcode = 6'h10;
    for (int i = 0; i < 16; i++) step("to_fetch_wait", 4'd0, 0, 0);
    for (int i = 0; i < 3; i++) step("to_fault", 4'd12, 1, 0);
    do_reset();
    for (int i = 0; i < 15; i++) step("to_edge_wait", 4'd0, 0, 0);
    step("to_edge_ready", 4'd0, 1, 0);
    step("to_edge_decode", 4'd1, 1, 0);
`else
    // Without the timeout, long waits never fault.
    do_reset();
    opcode = 6'h10;
    for (int i = 0; i < 20; i++) step("long_fetch_wait", 4'd0, 0, 0);
    step("long_fetch", 4'd0, 1, 0);
    step("long_decode", 4'd1, 1, 0);
`endif

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
